pattern_hist_engine: RTL and testbench

- Hardware engine that computes the 4-bit pattern-match histogram in data memory; it is the DUT-side counterpart of the Lab 18 checker.
- Reads the pattern from data memory, then scans SRC_COUNT bytes and counts, per byte, how many of the 5 nibble windows ([7:4],[6:3],[5:2],[4:1],[3:0]) equal the pattern.
- Writes histogram bins for match counts 1..5 back to memory and raises Halt.
- Sits beside the data memory on its single read/write port, under the same start/Halt control as TopLevel.

---
 rtl/pattern_hist_engine_pkg.sv | 25 ++
 rtl/pattern_hist_engine_if.sv | 21 ++
 rtl/pattern_hist_engine_nibble_match_count.sv | 20 ++
 rtl/pattern_hist_engine.sv | 147 ++++++++++++++
 tb/tb_pattern_hist_engine.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_hist_engine_pkg.sv
// Shared types for the pattern histogram engine: FSM states, window count
// and the histogram bin array.
package pattern_hist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAT,
    LOADP,
    SCAN,
    WR,
    DONE
  } state_t;

  // Number of 4-bit windows inside one byte: [7:4] down to [3:0].
  localparam int NUM_WIN = 5;

  // Bin k holds the number of bytes with exactly k matching windows.
  typedef logic [7:0] bin_arr_t [1:NUM_WIN];

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pattern_hist_engine_if.sv
// Single read/write port of the data memory. The engine is the master; the
// memory drives registered read data with one cycle of latency.
interface pattern_hist_engine_if #(
  parameter int AW = 8
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/pattern_hist_engine_nibble_match_count.sv
// Counts how many of the five overlapping nibble windows of a byte equal
// the 4-bit pattern. Purely combinational.
module nibble_match_count
  import pattern_hist_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic [3:0] i_pat,
  output logic [2:0] o_count
);

  // Sum of window equality hits, window k covering bits [k+3:k].
  always_comb begin
    // NOTE: o_count gets a value before the loop so every path assigns it and no latch is inferred.
    o_count = '0;
    for (int k = 0; k < NUM_WIN; k++) begin
      if (i_byte[k +: 4] == i_pat) o_count = o_count + 3'd1;
    end
  end

endmodule

// File: rtl/pattern_hist_engine.sv
// Pattern histogram engine: reads a pattern, scans SRC_COUNT source bytes one
// per cycle, bins them by number of matching nibble windows, writes bins
// 1..5 back to memory and raises Halt.
module pattern_hist_engine
  import pattern_hist_pkg::*;
#(
  parameter int AW        = 8,
  parameter int PAT_ADDR  = 9,
  parameter int SRC_BASE  = 32,
  parameter int SRC_COUNT = 64,
  parameter int HIST_BASE = 10
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  Halt,
  pattern_hist_engine_if.master bus,
  output logic [15:0]           cycle_ct
);

  localparam logic [7:0]    LAST_IDX = 8'(SRC_COUNT - 1);
  localparam logic [AW-1:0] PAT_A    = AW'(PAT_ADDR);
  localparam logic [AW-1:0] SRC_A    = AW'(SRC_BASE);
  localparam logic [AW-1:0] HIST_A   = AW'(HIST_BASE);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_pattern;
  bin_arr_t    r_bins;
  logic [7:0]  r_idx;
  logic [2:0]  r_j;
  logic [15:0] r_cycle_ct;
  logic [2:0]  w_count;
  logic [7:0]  w_bin_sel;

  nibble_match_count u_match (
    .i_byte  (bus.mem_rd_data),
    .i_pat   (r_pattern),
    .o_count (w_count)
  );

  // State register; start forces a synchronous return to IDLE from anywhere.
  always_ff @(posedge CLK or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n)     r_state <= IDLE;
    else if (start) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = PAT;
      PAT:     w_next = LOADP;
      LOADP:   w_next = SCAN;
      SCAN:    if (r_idx >= LAST_IDX) w_next = WR;
      WR:      if (r_j == 3'd4) w_next = DONE;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Bin selected for the current write slot (bin j+1).
  always_comb begin
    w_bin_sel = r_bins[1];
    for (int k = 1; k <= NUM_WIN; k++) begin
      if (32'(r_j) + 1 == k) w_bin_sel = r_bins[k];
    end
  end

  // Memory strobes decoded from state; suppressed while start holds the engine.
  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    if (!start) begin
      unique case (r_state)
        PAT: begin
          bus.mem_addr  = PAT_A;
          bus.mem_rd_en = 1'b1;
        end
        LOADP: begin
          bus.mem_addr  = SRC_A;
          bus.mem_rd_en = 1'b1;
        end
        SCAN: begin
          if (r_idx < LAST_IDX) begin
            bus.mem_addr  = SRC_A + AW'(r_idx) + AW'(1);
            bus.mem_rd_en = 1'b1;
          end
        end
        WR: begin
          bus.mem_addr    = HIST_A + AW'(r_j);
          bus.mem_wr_en   = 1'b1;
          bus.mem_wr_data = w_bin_sel;
        end
        default: ;
      endcase
    end
  end

  assign Halt     = (r_state == DONE);
  assign cycle_ct = r_cycle_ct;

  // Datapath: pattern capture, byte index, histogram bins and write slot.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= '0;
      r_idx     <= '0;
      r_j       <= '0;
      // NOTE: the bins are a handful of flops that must read zero after reset, so they are reset explicitly rather than left to a RAM.
      for (int k = 1; k <= NUM_WIN; k++) r_bins[k] <= '0;
    end else if (start) begin
      r_idx <= '0;
      r_j   <= '0;
      for (int k = 1; k <= NUM_WIN; k++) r_bins[k] <= '0;
    end else begin
      unique case (r_state)
        LOADP: begin
          r_pattern <= bus.mem_rd_data[3:0];
          r_idx     <= '0;
        end
        SCAN: begin
          for (int k = 1; k <= NUM_WIN; k++) begin
            if (32'(w_count) == k) r_bins[k] <= sat_inc8(r_bins[k]);
          end
          if (r_idx < LAST_IDX) r_idx <= r_idx + 8'd1;
          else                  r_j   <= '0;
        end
        WR:      r_j <= r_j + 3'd1;
        default: ;
      endcase
    end
  end

  // Busy-cycle counter, saturating at 0xFFFF.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)     r_cycle_ct <= '0;
    else if (start) r_cycle_ct <= '0;
    else if ((r_state == PAT || r_state == LOADP || r_state == SCAN || r_state == WR)
             && r_cycle_ct != 16'hFFFF)
      r_cycle_ct <= r_cycle_ct + 16'd1;
  end

endmodule

// File: tb/tb_pattern_hist_engine.sv
// Scoreboard bench for pattern_hist_engine: a behavioural memory, a reference
// histogram computed from memory contents, and a write monitor.
module tb_pattern_hist_engine;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b1;
  logic        Halt;
  logic [15:0] cycle_ct;

  logic [7:0]  mem [0:255];
  wr_t         sb [$];
  int          exp_bins [1:5];
  int          total = 0;
  int          bad = 0;

  pattern_hist_engine_if #(.AW(8)) bus ();

  pattern_hist_engine #(
    .AW(8), .PAT_ADDR(9), .SRC_BASE(32), .SRC_COUNT(64), .HIST_BASE(10)
  ) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .start    (start),
    .Halt     (Halt),
    .bus      (bus),
    .cycle_ct (cycle_ct)
  );

  always #5 CLK = ~CLK;

  initial bus.mem_rd_data = 8'h00;

  // Behavioural single-port memory with registered read.
  always @(posedge CLK) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every write must match the next expected write.
  always @(negedge CLK) begin
    if (bus.mem_rd_en && bus.mem_wr_en) begin
      total++;
      bad++;
      $display("FAIL rd_wr_overlap addr=%0d", bus.mem_addr);
    end
    if (bus.mem_wr_en) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%0d", bus.mem_addr, bus.mem_wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", int'(bus.mem_addr), int'(e.addr));
        check("wr_data", int'(bus.mem_wr_data), int'(e.data));
      end
    end
  end

  // Reference: histogram of window-match counts over the source bytes.
  task automatic expect_from_mem();
    int pat;
    pat = int'(mem[9][3:0]);
    for (int k = 1; k <= 5; k++) exp_bins[k] = 0;
    for (int i = 0; i < 64; i++) begin
      int b;
      int m;
      b = int'(mem[32 + i]);
      m = 0;
      for (int s = 0; s <= 4; s++) if (((b >> s) & 15) == pat) m++;
      if (m != 0 && exp_bins[m] < 255) exp_bins[m]++;
    end
    for (int j = 0; j < 5; j++) begin
      wr_t w;
      w.addr = 8'(10 + j);
      w.data = 8'(exp_bins[j + 1]);
      sb.push_back(w);
    end
  endtask

  // Leaves the engine in IDLE with start=1, aligned 2 time units after an edge.
  task automatic begin_idle();
    @(posedge CLK); #2 start = 1'b1;
    @(posedge CLK); #2;
  endtask

  // Counts edges after start drops until Halt, bounded.
  task automatic wait_halt(output int edges);
    bit done;
    edges = 0;
    done  = 1'b0;
    while (!done) begin
      @(posedge CLK);
      edges++;
      #1;
      if (Halt) done = 1'b1;
      else if (edges >= 300) begin
        total++;
        bad++;
        $display("FAIL halt_timeout edges=%0d required=72", edges);
        done = 1'b1;
      end
    end
  endtask

  task automatic finish_check(input string name, input int edges);
    check({name, "_latency"}, edges, 72);
    check({name, "_cycle_ct"}, int'(cycle_ct), 71);
    @(negedge CLK); #1;
    check({name, "_sb_empty"}, sb.size(), 0);
    for (int j = 0; j < 5; j++) check({name, "_mem_bin"}, int'(mem[10 + j]), exp_bins[j + 1]);
    repeat (3) @(posedge CLK);
    #1;
    check({name, "_halt_sticky"}, int'(Halt), 1);
    check({name, "_cycle_ct_hold"}, int'(cycle_ct), 71);
  endtask

  task automatic run_full(input string name);
    int n;
    expect_from_mem();
    start = 1'b0;
    wait_halt(n);
    finish_check(name, n);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] alt [0:3];
    logic [7:0] slide [0:4];
    alt   = '{8'hFF, 8'h0F, 8'h1E, 8'h3C};
    slide = '{8'hF0, 8'h78, 8'h3C, 8'h1E, 8'h0F};
    clear_mem();

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_halt", int'(Halt), 0);
    check("rst_rd_en", int'(bus.mem_rd_en), 0);
    check("rst_wr_en", int'(bus.mem_wr_en), 0);
    check("rst_addr", int'(bus.mem_addr), 0);
    check("rst_wr_data", int'(bus.mem_wr_data), 0);
    check("rst_cycle_ct", int'(cycle_ct), 0);
    @(posedge CLK); #2 rst_n = 1'b1;

    // Single byte with two overlapping window hits.
    begin_idle();
    clear_mem();
    mem[9]  = 8'h02;
    mem[32] = 8'h24;
    run_full("single");

    // All zeros with pattern 0000: every byte hits all five windows.
    begin_idle();
    clear_mem();
    run_full("zeros");

    // Pattern 1111 over an alternating set.
    begin_idle();
    clear_mem();
    mem[9] = 8'h0F;
    for (int i = 0; i < 64; i++) mem[32 + i] = alt[i % 4];
    run_full("alt");

    // Pattern 1111 sliding through each window position.
    begin_idle();
    clear_mem();
    mem[9] = 8'hAF;
    for (int i = 0; i < 64; i++) mem[32 + i] = slide[i % 5];
    run_full("slide");

    // Random contents and pattern.
    for (int r = 0; r < 4; r++) begin
      begin_idle();
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
      run_full("rand");
    end

    // Abort mid-scan with start, then rerun.
    begin_idle();
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
    start = 1'b0;
    repeat (23) @(posedge CLK);
    #1 check("abort_cycle_ct_pre", int'(cycle_ct), 22);
    #1 start = 1'b1;
    #1;
    check("abort_rd_gated", int'(bus.mem_rd_en), 0);
    check("abort_wr_gated", int'(bus.mem_wr_en), 0);
    @(posedge CLK); #1;
    check("abort_halt", int'(Halt), 0);
    check("abort_cycle_ct", int'(cycle_ct), 0);
    check("abort_idle_rd", int'(bus.mem_rd_en), 0);
    @(posedge CLK); #2;
    run_full("rerun");

    // Asynchronous reset in the middle of the write phase, then resume.
    begin_idle();
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
    expect_from_mem();
    start = 1'b0;
    repeat (69) @(posedge CLK);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_halt", int'(Halt), 0);
    check("arst_rd_en", int'(bus.mem_rd_en), 0);
    check("arst_wr_en", int'(bus.mem_wr_en), 0);
    check("arst_addr", int'(bus.mem_addr), 0);
    check("arst_wr_data", int'(bus.mem_wr_data), 0);
    check("arst_cycle_ct", int'(cycle_ct), 0);
    repeat (3) @(posedge CLK);
    #1;
    check("arst_hold_cycle_ct", int'(cycle_ct), 0);
    check("arst_hold_rd_en", int'(bus.mem_rd_en), 0);
    @(posedge CLK); #2;
    expect_from_mem();
    rst_n = 1'b1;
    wait_halt(n);
    finish_check("resume", n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
